// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the MEM-stage data-memory responder.
package mem_pkg;

    // Access-size encodings carried on tipo
    localparam logic [1:0] TIPO_WORD   = 2'b00;
    localparam logic [1:0] TIPO_HALF   = 2'b01;
    localparam logic [1:0] TIPO_BYTE   = 2'b10;
    localparam logic [1:0] TIPO_ILEGAL = 2'b11;

    // Wait-state counter width; covers WAIT_CYCLES up to 15
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    // True when the access cannot be serviced: bad alignment or illegal size
    function automatic logic desalineado(input logic [1:0] tipo, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (tipo)
            TIPO_WORD: bad = (off != 2'b00);
            TIPO_HALF: bad = off[0];
            TIPO_BYTE: bad = 1'b0;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/sram_1p.sv
// Single-port synchronous word RAM with byte-write enables and registered read data.
module sram_1p #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [0:(1 << ADDR_W)-1];

    // Enabled access: write selected byte lanes, register the addressed word
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_datos_responder.sv
// Data-memory responder: request FSM, wait-state counter, lane steering and load extension.
module mem_datos_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] direccion,
    input  logic [31:0] din,
    input  logic [1:0]  tipo,
    input  logic        signo,
    output logic [31:0] dout,
    output logic        stall,
    output logic        error
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  idx_q;
    logic [1:0]         off_q;
    logic [31:0]        din_q;
    logic [1:0]         tipo_q;
    logic               signo_q;
    logic               we_q;
    logic               err_q;

    logic               req;
    logic               req_bad;
    logic               accept;
    logic               ram_en;
    logic [3:0]         ram_be;
    logic [31:0]        ram_wdata;
    logic [31:0]        ram_rdata;
    logic [31:0]        rd_shift;
    logic [31:0]        ld_ext;

    // Upper address bits above the word index are deliberately ignored (address wraps)
    logic unused_dir;
    assign unused_dir = ^direccion[31:ADDR_W+2];

    assign req     = read | write;
    assign req_bad = desalineado(tipo, direccion[1:0]) | (read & write);
    assign accept  = (state_q == StIdle) & req;

    // State, counter and request latch; reset drops any pending access
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            off_q   <= '0;
            din_q   <= '0;
            tipo_q  <= TIPO_WORD;
            signo_q <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= direccion[ADDR_W+1:2];
                off_q   <= direccion[1:0];
                din_q   <= din;
                tipo_q  <= tipo;
                signo_q <= signo;
                we_q    <= write;
                err_q   <= req_bad;
            end
        end
    end

    // Next state, wait-state countdown and RAM issue
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ram_en  = 1'b0;
        case (state_q)
            StIdle: begin
                if (req) begin
                    if (req_bad) begin
                        state_d = StResp;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    ram_en  = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Store lane steering: replicate data across lanes, enable only the addressed bytes
    always_comb begin
        ram_be    = 4'b1111;
        ram_wdata = din_q;
        case (tipo_q)
            TIPO_BYTE: begin
                ram_be    = 4'b0001 << off_q;
                ram_wdata = {4{din_q[7:0]}};
            end
            TIPO_HALF: begin
                ram_be    = off_q[1] ? 4'b1100 : 4'b0011;
                ram_wdata = {2{din_q[15:0]}};
            end
            default: begin
                ram_be    = 4'b1111;
                ram_wdata = din_q;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        rd_shift = ram_rdata >> {off_q, 3'b000};
        ld_ext   = ram_rdata;
        case (tipo_q)
            TIPO_BYTE: ld_ext = {{24{signo_q & rd_shift[7]}}, rd_shift[7:0]};
            TIPO_HALF: ld_ext = {{16{signo_q & rd_shift[15]}}, rd_shift[15:0]};
            default:   ld_ext = ram_rdata;
        endcase
    end

    // Outputs: response data/error only in RESP, forced low while reset is asserted
    always_comb begin
        stall = req & (state_q != StResp);
        error = (state_q == StResp) & err_q & ~reset;
        dout  = '0;
        if ((state_q == StResp) && !err_q && !we_q && !reset) begin
            dout = ld_ext;
        end
    end

    sram_1p #(
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk   (clk),
        .en    (ram_en & ~reset),
        .we    (we_q),
        .be    (ram_be),
        .addr  (idx_q),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule
